// File: rtl/osd_pkg.sv
// Shared definitions for the OSD command arbiter: command codes, owner
// encoding and arbiter state type.
package osd_pkg;

  // OSD command opcodes carried in the first (start) byte of a packet
  localparam logic [7:0] OSD_CMD_ENABLE = 8'd1;
  localparam logic [7:0] OSD_CMD_TILE   = 8'd2;

  // Which requester a decision refers to
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_e;

  // Arbiter states
  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN_A,
    S_OWN_B
  } state_e;

endpackage

// File: rtl/osd_rr_pick.sv
// Two-requester round-robin picker, purely combinational. On a tie the
// requester that did not own the interface last wins.
module osd_rr_pick
  import osd_pkg::*;
(
  input  logic   req_a,
  input  logic   req_b,
  input  owner_e last_owner,
  output owner_e winner
);

  // Single requester wins outright; a tie goes to the one not served last
  always_comb begin
    winner = OWN_NONE;
    if (req_a && req_b) begin
      winner = (last_owner == OWN_A) ? OWN_B : OWN_A;
    end else if (req_a) begin
      winner = OWN_A;
    end else if (req_b) begin
      winner = OWN_B;
    end
  end

endmodule

// File: rtl/osd_cmd_arbiter.sv
// Arbiter sharing one OSD byte-command interface between port A (host)
// and port B (local status source). Packets are atomic: a grant lasts
// until the owner drops req. Output strobes are spaced by STROBE_GAP and
// continuation bytes arriving before a packet's command byte are dropped.
// Optional feature: define OSD_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT cycles without an accepted byte.
module osd_cmd_arbiter
  import osd_pkg::*;
#(
  parameter int STROBE_GAP = 1,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  output logic       a_gnt,
  input  logic       a_strobe,
  input  logic       a_start,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_req,
  output logic       b_gnt,
  input  logic       b_strobe,
  input  logic       b_start,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  output logic       err_pulse,
  output logic       timeout_pulse
);

  if (STROBE_GAP < 1 || STROBE_GAP > 255) begin : g_bad_gap
    $error("STROBE_GAP must be within 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..65535");
  end

  localparam logic [7:0] GAP_M1 = 8'(STROBE_GAP - 1);

  state_e     state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic [7:0] pace_cnt_q, pace_cnt_d;
  logic       synced_q, synced_d;
  logic       out_strobe_q, out_strobe_d;
  logic       out_start_q, out_start_d;
  logic [7:0] out_data_q, out_data_d;
  logic       err_q, err_d;

  owner_e     rr_winner;
  logic       pace_zero;
  logic       a_acc, b_acc, acc;
  logic       acc_start;
  logic [7:0] acc_data;

  osd_rr_pick u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_owner (last_owner_q),
    .winner     (rr_winner)
  );

  assign a_gnt     = (state_q == S_OWN_A);
  assign b_gnt     = (state_q == S_OWN_B);
  assign pace_zero = (pace_cnt_q == 8'd0);
  // Only the current owner, still requesting and past the pacing gap, is ready
  assign a_ready   = a_gnt && a_req && pace_zero;
  assign b_ready   = b_gnt && b_req && pace_zero;
  assign a_acc     = a_strobe && a_ready;
  assign b_acc     = b_strobe && b_ready;
  assign acc       = a_acc || b_acc;
  assign acc_start = a_acc ? a_start : b_start;
  assign acc_data  = a_acc ? a_data : b_data;

  assign data_out_strobe = out_strobe_q;
  assign data_out_start  = out_start_q;
  assign data_out        = out_data_q;
  assign err_pulse       = err_q;

`ifdef OSD_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              to_pulse_q, to_pulse_d;
  owner_e            cur_owner;

  assign cur_owner     = (state_q == S_OWN_A) ? OWN_A : OWN_B;
  assign timeout_pulse = to_pulse_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  // Next-state: arbitration, release, byte forwarding and pacing
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    pace_cnt_d   = pace_zero ? 8'd0 : pace_cnt_q - 8'd1;
    synced_d     = synced_q;
    out_strobe_d = 1'b0;
    out_start_d  = out_start_q;
    out_data_d   = out_data_q;
    err_d        = 1'b0;
`ifdef OSD_ARB_TIMEOUT_EN
    idle_cnt_d   = '0;
    to_pulse_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rr_winner == OWN_A) begin
          state_d = S_OWN_A;
        end else if (rr_winner == OWN_B) begin
          state_d = S_OWN_B;
        end
      end
      S_OWN_A: begin
        if (!a_req) begin
          state_d      = S_IDLE;
          last_owner_d = OWN_A;
        end
      end
      S_OWN_B: begin
        if (!b_req) begin
          state_d      = S_IDLE;
          last_owner_d = OWN_B;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte before the command byte of the packet is dropped and flagged
    if (acc) begin
      if (!synced_q && !acc_start) begin
        err_d = 1'b1;
      end else begin
        out_strobe_d = 1'b1;
        out_start_d  = acc_start;
        out_data_d   = acc_data;
        synced_d     = 1'b1;
        pace_cnt_d   = GAP_M1;
      end
    end

`ifdef OSD_ARB_TIMEOUT_EN
    // Revoke a grant whose owner has gone quiet; an accept restarts the count
    if (state_q != S_IDLE && state_d != S_IDLE && !acc) begin
      if (idle_cnt_q == IDLE_LAST) begin
        state_d      = S_IDLE;
        last_owner_d = cur_owner;
        to_pulse_d   = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif

    // Packet context never survives a change of owner
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      synced_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_B;
      pace_cnt_q   <= 8'd0;
      synced_q     <= 1'b0;
      out_strobe_q <= 1'b0;
      out_start_q  <= 1'b0;
      out_data_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      pace_cnt_q   <= pace_cnt_d;
      synced_q     <= synced_d;
      out_strobe_q <= out_strobe_d;
      out_start_q  <= out_start_d;
      out_data_q   <= out_data_d;
      err_q        <= err_d;
    end
  end

`ifdef OSD_ARB_TIMEOUT_EN
  // Idle counter and revoke pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      to_pulse_q <= to_pulse_d;
    end
  end
`endif

endmodule
